// File: rtl/reorder_buffer_pkg.sv
// Shared widths, constants and helpers for the reorder buffer slice.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_DEFAULT = 4;
  localparam int REG_IDX_WIDTH     = 5;
  localparam int DATA_WIDTH        = 32;

  typedef logic [REG_IDX_WIDTH-1:0] regIdx_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  localparam regIdx_t ZERO_REG = '0;

  // A commit only touches the register file when it has a real destination;
  // register 0 is hardwired and never written.
  function automatic logic writesRegister(input logic hasRd, input regIdx_t rd);
    return hasRd && (rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of issue, completion, operand-lookup and commit signals around the ROB.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) ();

  logic                 readyIn;

  logic                 issueValid;
  logic                 issueHasRd;
  regIdx_t              issueRd;
  logic [ROB_WIDTH-1:0] issueId;
  logic                 full;
  logic                 empty;

  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbId;
  data_t                cdbValue;
  logic                 cdbMispredict;
  data_t                cdbTarget;

  logic [ROB_WIDTH-1:0] query1Id;
  logic [ROB_WIDTH-1:0] query2Id;
  logic                 query1Ready;
  logic                 query2Ready;
  data_t                query1Value;
  data_t                query2Value;

  logic                 writeFlag;
  logic [ROB_WIDTH-1:0] robId;
  regIdx_t              writeAddr;
  data_t                writeValue;

  logic                 clearOut;
  data_t                clearPc;

  modport master (
    output readyIn, issueValid, issueHasRd, issueRd,
    output cdbValid, cdbId, cdbValue, cdbMispredict, cdbTarget,
    output query1Id, query2Id,
    input  issueId, full, empty,
    input  query1Ready, query2Ready, query1Value, query2Value,
    input  writeFlag, robId, writeAddr, writeValue, clearOut, clearPc
  );

  modport slave (
    input  readyIn, issueValid, issueHasRd, issueRd,
    input  cdbValid, cdbId, cdbValue, cdbMispredict, cdbTarget,
    input  query1Id, query2Id,
    output issueId, full, empty,
    output query1Ready, query2Ready, query1Value, query2Value,
    output writeFlag, robId, writeAddr, writeValue, clearOut, clearPc
  );

endinterface

// File: rtl/rob_query_port.sv
// Operand lookup by rename tag, with same-cycle forwarding from the CDB.
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic [ROB_WIDTH-1:0]      i_queryId,
  input  logic [(1<<ROB_WIDTH)-1:0] i_entryValid,
  input  logic [(1<<ROB_WIDTH)-1:0] i_entryReady,
  input  data_t                     i_entryValue [1<<ROB_WIDTH],
  input  logic                      i_cdbValid,
  input  logic [ROB_WIDTH-1:0]      i_cdbId,
  input  data_t                     i_cdbValue,
  output logic                      o_queryReady,
  output data_t                     o_queryValue
);

  logic w_cdbHit;

  // A broadcast for the looked-up tag counts as a result even before it is stored
  assign w_cdbHit     = i_cdbValid && (i_cdbId == i_queryId);
  assign o_queryReady = i_entryValid[i_queryId] && (i_entryReady[i_queryId] || w_cdbHit);
  assign o_queryValue = w_cdbHit ? i_cdbValue : i_entryValue[i_queryId];

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order completion,
// in-order commit, and a full flush when a mispredicted entry retires.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input logic             clockIn,
  input logic             resetIn,
  reorder_buffer_if.slave bus
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam int CNT_W = ROB_WIDTH + 1;

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_ready;
  logic [DEPTH-1:0]     r_mispredict;
  logic [DEPTH-1:0]     r_hasRd;
  regIdx_t              r_rd     [DEPTH];
  data_t                r_value  [DEPTH];
  data_t                r_target [DEPTH];

  logic [ROB_WIDTH-1:0] r_headPtr;
  logic [ROB_WIDTH-1:0] r_tailPtr;
  logic [CNT_W-1:0]     r_count;

  logic                 r_writeFlag;
  logic [ROB_WIDTH-1:0] r_robId;
  regIdx_t              r_writeAddr;
  data_t                r_writeValue;
  logic                 r_clearOut;
  data_t                r_clearPc;

  logic w_full;
  logic w_empty;
  logic w_commit;
  logic w_flush;
  logic w_issue;
  logic w_cdbWrite;

  // Occupancy and the per-cycle events; a flush suppresses issue and completion
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_commit   = bus.readyIn && r_valid[r_headPtr] && r_ready[r_headPtr];
  assign w_flush    = w_commit && r_mispredict[r_headPtr];
  assign w_issue    = bus.issueValid && !w_full && bus.readyIn && !w_flush;
  assign w_cdbWrite = bus.cdbValid && bus.readyIn && r_valid[bus.cdbId] && !w_flush;

  // Status flags per entry; a flush drops every in-flight entry at once
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_valid      <= '0;
      r_ready      <= '0;
      r_mispredict <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
    end else begin
      if (w_commit) begin
        r_valid[r_headPtr] <= 1'b0;
      end
      if (w_issue) begin
        r_valid[r_tailPtr]      <= 1'b1;
        r_ready[r_tailPtr]      <= 1'b0;
        r_mispredict[r_tailPtr] <= 1'b0;
      end
      if (w_cdbWrite) begin
        r_ready[bus.cdbId]      <= 1'b1;
        r_mispredict[bus.cdbId] <= bus.cdbMispredict;
      end
    end
  end

  // Payload fields carry no reset; they are only ever read behind a valid bit
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      if (w_issue) begin
        r_hasRd[r_tailPtr] <= bus.issueHasRd;
        r_rd[r_tailPtr]    <= bus.issueRd;
      end
      if (w_cdbWrite) begin
        r_value[bus.cdbId]  <= bus.cdbValue;
        r_target[bus.cdbId] <= bus.cdbTarget;
      end
    end
  end

  // Head, tail and occupancy; pointers wrap naturally at the buffer depth
  always_ff @(posedge clockIn) begin
    if (resetIn || w_flush) begin
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
    end else begin
      if (w_issue) begin
        r_tailPtr <= r_tailPtr + ROB_WIDTH'(1);
      end
      if (w_commit) begin
        r_headPtr <= r_headPtr + ROB_WIDTH'(1);
      end
      case ({w_issue, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered commit port and redirect; the flags are single-cycle pulses
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_writeFlag  <= 1'b0;
      r_robId      <= '0;
      r_writeAddr  <= '0;
      r_writeValue <= '0;
      r_clearOut   <= 1'b0;
      r_clearPc    <= '0;
    end else begin
      r_writeFlag <= w_commit && writesRegister(r_hasRd[r_headPtr], r_rd[r_headPtr]);
      r_clearOut  <= w_flush;
      if (w_commit) begin
        r_robId      <= r_headPtr;
        r_writeAddr  <= r_rd[r_headPtr];
        r_writeValue <= r_value[r_headPtr];
      end
      if (w_flush) begin
        r_clearPc <= r_target[r_headPtr];
      end
    end
  end

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query1 (
    .i_queryId    (bus.query1Id),
    .i_entryValid (r_valid),
    .i_entryReady (r_ready),
    .i_entryValue (r_value),
    .i_cdbValid   (bus.cdbValid),
    .i_cdbId      (bus.cdbId),
    .i_cdbValue   (bus.cdbValue),
    .o_queryReady (bus.query1Ready),
    .o_queryValue (bus.query1Value)
  );

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query2 (
    .i_queryId    (bus.query2Id),
    .i_entryValid (r_valid),
    .i_entryReady (r_ready),
    .i_entryValue (r_value),
    .i_cdbValid   (bus.cdbValid),
    .i_cdbId      (bus.cdbId),
    .i_cdbValue   (bus.cdbValue),
    .o_queryReady (bus.query2Ready),
    .o_queryValue (bus.query2Value)
  );

  assign bus.issueId    = r_tailPtr;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.writeFlag  = r_writeFlag;
  assign bus.robId      = r_robId;
  assign bus.writeAddr  = r_writeAddr;
  assign bus.writeValue = r_writeValue;
  assign bus.clearOut   = r_clearOut;
  assign bus.clearPc    = r_clearPc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized
// run compared against a queue-based model of the buffer.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int RW    = 4;
  localparam int DEPTH = 16;

  logic clockIn = 1'b0;
  logic resetIn = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;

  reorder_buffer_if #(.ROB_WIDTH(RW)) bus ();

  reorder_buffer #(.ROB_WIDTH(RW)) dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .bus     (bus)
  );

  always #5 clockIn = ~clockIn;

  // Model: the queue holds in-flight entries oldest first; entry k has id (mHead+k) mod DEPTH
  typedef struct {
    logic        hasRd;
    logic [4:0]  rd;
    logic        ready;
    logic [31:0] value;
    logic        misp;
    logic [31:0] target;
  } modelEntry_t;

  modelEntry_t   mRob[$];
  int            mHead = 0;
  int            mTail = 0;
  logic          mWriteFlag = 1'b0;
  logic [RW-1:0] mRobId = '0;
  logic [4:0]    mWriteAddr = '0;
  logic [31:0]   mWriteValue = '0;
  logic          mClearOut = 1'b0;
  logic [31:0]   mClearPc = '0;

  function automatic int modelPos(input logic [RW-1:0] id);
    int pos;
    pos = (int'(id) - mHead + DEPTH) % DEPTH;
    return (pos < mRob.size()) ? pos : -1;
  endfunction

  function automatic void modelQuery(input logic [RW-1:0] id, output logic rdy, output logic [31:0] val);
    int pos;
    pos = modelPos(id);
    rdy = 1'b0;
    val = '0;
    if (pos >= 0) begin
      if (bus.cdbValid && bus.cdbId == id) begin
        rdy = 1'b1;
        val = bus.cdbValue;
      end else if (mRob[pos].ready) begin
        rdy = 1'b1;
        val = mRob[pos].value;
      end
    end
  endfunction

  // Advance the model by one cycle from the currently driven inputs, then clock the DUT
  task automatic applyStimulus();
    modelEntry_t e;
    int   pos;
    logic commit, flush, issue;
    if (resetIn) begin
      mRob.delete();
      mHead = 0; mTail = 0;
      mWriteFlag = 1'b0; mRobId = '0; mWriteAddr = '0; mWriteValue = '0;
      mClearOut = 1'b0; mClearPc = '0;
    end else if (!bus.readyIn) begin
      mWriteFlag = 1'b0;
      mClearOut  = 1'b0;
    end else begin
      commit = (mRob.size() > 0) && mRob[0].ready;
      flush  = commit && mRob[0].misp;
      issue  = bus.issueValid && (mRob.size() < DEPTH) && !flush;
      mWriteFlag = commit && mRob[0].hasRd && (mRob[0].rd != '0);
      mClearOut  = flush;
      if (commit) begin
        mRobId      = RW'(mHead);
        mWriteAddr  = mRob[0].rd;
        mWriteValue = mRob[0].value;
      end
      if (flush) mClearPc = mRob[0].target;
      pos = modelPos(bus.cdbId);
      if (bus.cdbValid && !flush && pos >= 0) begin
        e = mRob[pos];
        e.ready = 1'b1; e.value = bus.cdbValue; e.misp = bus.cdbMispredict; e.target = bus.cdbTarget;
        mRob[pos] = e;
      end
      if (flush) begin
        mRob.delete();
        mHead = 0; mTail = 0;
      end else begin
        if (commit) begin
          void'(mRob.pop_front());
          mHead = (mHead + 1) % DEPTH;
        end
        if (issue) begin
          e.hasRd = bus.issueHasRd; e.rd = bus.issueRd; e.ready = 1'b0;
          e.value = '0; e.misp = 1'b0; e.target = '0;
          mRob.push_back(e);
          mTail = (mTail + 1) % DEPTH;
        end
      end
    end
    @(posedge clockIn);
    #1;
  endtask

  task automatic idleInputs();
    bus.readyIn = 1'b1;
    bus.issueValid = 1'b0; bus.issueHasRd = 1'b0; bus.issueRd = '0;
    bus.cdbValid = 1'b0; bus.cdbId = '0; bus.cdbValue = '0;
    bus.cdbMispredict = 1'b0; bus.cdbTarget = '0;
    bus.query1Id = '0; bus.query2Id = '0;
  endtask

  task automatic driveCdb(input logic [RW-1:0] id, input logic [31:0] val, input logic misp, input logic [31:0] tgt);
    bus.cdbValid = 1'b1; bus.cdbId = id; bus.cdbValue = val;
    bus.cdbMispredict = misp; bus.cdbTarget = tgt;
  endtask

  task automatic test_reset();
    idleInputs();
    resetIn = 1'b1;
    bus.issueValid = 1'b1; bus.issueHasRd = 1'b1; bus.issueRd = 5'd9;
    driveCdb(RW'($urandom), 32'($urandom), 1'b1, 32'($urandom));
    applyStimulus();
    applyStimulus();
    idleInputs();
    resetIn = 1'b0;
    #1;
    checkCount++; if (bus.empty !== 1'b1) begin failCount++; $display("[TB] FAIL reset_empty: got %0b expected 1", bus.empty); end
    checkCount++; if (bus.full !== 1'b0) begin failCount++; $display("[TB] FAIL reset_full: got %0b expected 0", bus.full); end
    checkCount++; if (bus.issueId !== 4'd0) begin failCount++; $display("[TB] FAIL reset_issueId: got %0d expected 0", bus.issueId); end
    checkCount++; if (bus.writeFlag !== 1'b0) begin failCount++; $display("[TB] FAIL reset_writeFlag: got %0b expected 0", bus.writeFlag); end
    checkCount++; if (bus.robId !== 4'd0) begin failCount++; $display("[TB] FAIL reset_robId: got %0d expected 0", bus.robId); end
    checkCount++; if (bus.writeAddr !== 5'd0) begin failCount++; $display("[TB] FAIL reset_writeAddr: got %0d expected 0", bus.writeAddr); end
    checkCount++; if (bus.writeValue !== 32'd0) begin failCount++; $display("[TB] FAIL reset_writeValue: got %0h expected 0", bus.writeValue); end
    checkCount++; if (bus.clearOut !== 1'b0) begin failCount++; $display("[TB] FAIL reset_clearOut: got %0b expected 0", bus.clearOut); end
    checkCount++; if (bus.clearPc !== 32'd0) begin failCount++; $display("[TB] FAIL reset_clearPc: got %0h expected 0", bus.clearPc); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      bus.issueValid = 1'b1; bus.issueHasRd = 1'b1; bus.issueRd = 5'(i + 1);
      #1;
      checkCount++; if (bus.issueId !== 4'(i)) begin failCount++; $display("[TB] FAIL fill_issueId: got %0d expected %0d", bus.issueId, i); end
      checkCount++; if (bus.full !== 1'b0) begin failCount++; $display("[TB] FAIL fill_notFull at %0d: got %0b expected 0", i, bus.full); end
      applyStimulus();
    end
    checkCount++; if (bus.full !== 1'b1) begin failCount++; $display("[TB] FAIL fill_full: got %0b expected 1", bus.full); end
    checkCount++; if (bus.empty !== 1'b0) begin failCount++; $display("[TB] FAIL fill_empty: got %0b expected 0", bus.empty); end
    bus.issueRd = 5'd17;
    applyStimulus();
    bus.issueValid = 1'b0;
    checkCount++; if (bus.issueId !== 4'd0) begin failCount++; $display("[TB] FAIL fill_overflow_tail: got %0d expected 0", bus.issueId); end
    checkCount++; if (bus.full !== 1'b1) begin failCount++; $display("[TB] FAIL fill_overflow_full: got %0b expected 1", bus.full); end
  endtask

  task automatic test_out_of_order_commit();
    driveCdb(4'd2, 32'h55, 1'b0, 32'h0);
    applyStimulus();
    checkCount++; if (bus.writeFlag !== 1'b0) begin failCount++; $display("[TB] FAIL ooo_noCommitId2: got %0b expected 0", bus.writeFlag); end
    driveCdb(4'd0, 32'h11, 1'b0, 32'h0);
    applyStimulus();
    checkCount++; if (bus.writeFlag !== 1'b0) begin failCount++; $display("[TB] FAIL ooo_sameCycleCommit: got %0b expected 0", bus.writeFlag); end
    driveCdb(4'd1, 32'h22, 1'b0, 32'h0);
    applyStimulus();
    bus.cdbValid = 1'b0;
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue} !== {1'b1, 4'd0, 5'd1, 32'h11}) begin
      failCount++; $display("[TB] FAIL ooo_commit0: got flag=%0b id=%0d addr=%0d val=%0h expected 1/0/1/11", bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue); end
    applyStimulus();
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue} !== {1'b1, 4'd1, 5'd2, 32'h22}) begin
      failCount++; $display("[TB] FAIL ooo_commit1: got flag=%0b id=%0d addr=%0d val=%0h expected 1/1/2/22", bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue); end
    applyStimulus();
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue} !== {1'b1, 4'd2, 5'd3, 32'h55}) begin
      failCount++; $display("[TB] FAIL ooo_commit2: got flag=%0b id=%0d addr=%0d val=%0h expected 1/2/3/55", bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue); end
    applyStimulus();
    checkCount++; if (bus.writeFlag !== 1'b0) begin failCount++; $display("[TB] FAIL ooo_stallAtId3: got %0b expected 0", bus.writeFlag); end
  endtask

  task automatic test_query_forward();
    bus.query1Id = 4'd3; bus.query2Id = 4'd4;
    driveCdb(4'd3, 32'hABCD, 1'b0, 32'h0);
    #1;
    checkCount++; if (bus.query1Ready !== 1'b1) begin failCount++; $display("[TB] FAIL fwd_ready: got %0b expected 1", bus.query1Ready); end
    checkCount++; if (bus.query1Value !== 32'hABCD) begin failCount++; $display("[TB] FAIL fwd_value: got %0h expected abcd", bus.query1Value); end
    checkCount++; if (bus.query2Ready !== 1'b0) begin failCount++; $display("[TB] FAIL fwd_otherNotReady: got %0b expected 0", bus.query2Ready); end
    applyStimulus();
    bus.cdbValid = 1'b0;
    #1;
    checkCount++; if ({bus.query1Ready, bus.query1Value} !== {1'b1, 32'hABCD}) begin
      failCount++; $display("[TB] FAIL fwd_stored: got rdy=%0b val=%0h expected 1/abcd", bus.query1Ready, bus.query1Value); end
    applyStimulus();
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue} !== {1'b1, 4'd3, 5'd4, 32'hABCD}) begin
      failCount++; $display("[TB] FAIL fwd_commit3: got flag=%0b id=%0d addr=%0d val=%0h expected 1/3/4/abcd", bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue); end
  endtask

  task automatic test_zero_rd();
    idleInputs();
    resetIn = 1'b1;
    applyStimulus();
    resetIn = 1'b0;
    bus.issueValid = 1'b1; bus.issueHasRd = 1'b1; bus.issueRd = 5'd0;
    applyStimulus();
    bus.issueHasRd = 1'b0; bus.issueRd = 5'd7;
    applyStimulus();
    bus.issueValid = 1'b0;
    driveCdb(4'd0, 32'h77, 1'b0, 32'h0);
    applyStimulus();
    driveCdb(4'd1, 32'h88, 1'b0, 32'h0);
    applyStimulus();
    bus.cdbValid = 1'b0;
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue} !== {1'b0, 4'd0, 5'd0, 32'h77}) begin
      failCount++; $display("[TB] FAIL zero_rd_commit: got flag=%0b id=%0d addr=%0d val=%0h expected 0/0/0/77", bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue); end
    checkCount++; if (bus.empty !== 1'b0) begin failCount++; $display("[TB] FAIL zero_rd_oneLeft: got %0b expected 0", bus.empty); end
    applyStimulus();
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr} !== {1'b0, 4'd1, 5'd7}) begin
      failCount++; $display("[TB] FAIL no_rd_commit: got flag=%0b id=%0d addr=%0d expected 0/1/7", bus.writeFlag, bus.robId, bus.writeAddr); end
    checkCount++; if ({bus.empty, bus.issueId} !== {1'b1, 4'd2}) begin
      failCount++; $display("[TB] FAIL zero_rd_drained: got empty=%0b issueId=%0d expected 1/2", bus.empty, bus.issueId); end
  endtask

  task automatic test_mispredict_flush();
    bus.issueValid = 1'b1; bus.issueHasRd = 1'b1; bus.issueRd = 5'd5;
    applyStimulus();
    bus.issueRd = 5'd6;
    applyStimulus();
    bus.issueRd = 5'd9;
    applyStimulus();
    bus.issueValid = 1'b0;
    driveCdb(4'd2, 32'h99, 1'b1, 32'h1000);
    applyStimulus();
    bus.issueValid = 1'b1; bus.issueRd = 5'd10;
    driveCdb(4'd3, 32'h33, 1'b0, 32'h0);
    applyStimulus();
    idleInputs();
    bus.query1Id = 4'd3;
    #1;
    checkCount++; if ({bus.clearOut, bus.clearPc} !== {1'b1, 32'h1000}) begin
      failCount++; $display("[TB] FAIL flush_redirect: got clear=%0b pc=%0h expected 1/1000", bus.clearOut, bus.clearPc); end
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue} !== {1'b1, 4'd2, 5'd5, 32'h99}) begin
      failCount++; $display("[TB] FAIL flush_write: got flag=%0b id=%0d addr=%0d val=%0h expected 1/2/5/99", bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue); end
    checkCount++; if ({bus.empty, bus.full, bus.issueId} !== {1'b1, 1'b0, 4'd0}) begin
      failCount++; $display("[TB] FAIL flush_state: got empty=%0b full=%0b issueId=%0d expected 1/0/0", bus.empty, bus.full, bus.issueId); end
    checkCount++; if (bus.query1Ready !== 1'b0) begin failCount++; $display("[TB] FAIL flush_cdbDropped: got %0b expected 0", bus.query1Ready); end
    applyStimulus();
    checkCount++; if ({bus.clearOut, bus.writeFlag} !== 2'b00) begin
      failCount++; $display("[TB] FAIL flush_pulse: got clear=%0b flag=%0b expected 0/0", bus.clearOut, bus.writeFlag); end
  endtask

  task automatic test_ready_stall();
    bus.issueValid = 1'b1; bus.issueHasRd = 1'b1; bus.issueRd = 5'd12;
    applyStimulus();
    bus.issueValid = 1'b0;
    driveCdb(4'd0, 32'h4242, 1'b0, 32'h0);
    applyStimulus();
    bus.cdbValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.readyIn = 1'b0; bus.issueValid = 1'b1; bus.issueRd = 5'd13;
      applyStimulus();
      checkCount++; if ({bus.writeFlag, bus.empty, bus.issueId} !== {1'b0, 1'b0, 4'd1}) begin
        failCount++; $display("[TB] FAIL stall_hold %0d: got flag=%0b empty=%0b issueId=%0d expected 0/0/1", i, bus.writeFlag, bus.empty, bus.issueId); end
    end
    bus.readyIn = 1'b1; bus.issueValid = 1'b0;
    applyStimulus();
    checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue, bus.empty} !== {1'b1, 4'd0, 5'd12, 32'h4242, 1'b1}) begin
      failCount++; $display("[TB] FAIL stall_release: got flag=%0b id=%0d addr=%0d val=%0h empty=%0b expected 1/0/12/4242/1",
                            bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue, bus.empty); end
  endtask

  task automatic test_random();
    logic        expRdy1, expRdy2;
    logic [31:0] expVal1, expVal2;
    idleInputs();
    resetIn = 1'b1;
    applyStimulus();
    resetIn = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      resetIn           = ($urandom_range(0, 299) == 0);
      bus.readyIn       = ($urandom_range(0, 9) != 0);
      bus.issueValid    = ($urandom_range(0, 9) < 6);
      bus.issueHasRd    = 1'($urandom_range(0, 1));
      bus.issueRd       = 5'($urandom);
      bus.cdbValid      = ($urandom_range(0, 9) < 7);
      if (mRob.size() > 0 && $urandom_range(0, 3) != 0)
        bus.cdbId = RW'((mHead + int'($urandom_range(0, mRob.size() - 1))) % DEPTH);
      else
        bus.cdbId = RW'($urandom);
      bus.cdbValue      = 32'($urandom);
      bus.cdbMispredict = ($urandom_range(0, 19) == 0);
      bus.cdbTarget     = 32'($urandom);
      bus.query1Id      = ($urandom_range(0, 1) == 0) ? bus.cdbId : RW'($urandom);
      bus.query2Id      = RW'($urandom);
      #1;
      modelQuery(bus.query1Id, expRdy1, expVal1);
      modelQuery(bus.query2Id, expRdy2, expVal2);
      checkCount++; if ({bus.issueId, bus.full, bus.empty} !== {RW'(mTail), mRob.size() == DEPTH, mRob.size() == 0}) begin
        failCount++; $display("[TB] FAIL rand_status cyc %0d: got id=%0d full=%0b empty=%0b expected %0d/%0b/%0b",
                              cyc, bus.issueId, bus.full, bus.empty, mTail, mRob.size() == DEPTH, mRob.size() == 0); end
      checkCount++; if (bus.query1Ready !== expRdy1 || (expRdy1 && bus.query1Value !== expVal1)) begin
        failCount++; $display("[TB] FAIL rand_query1 cyc %0d: got rdy=%0b val=%0h expected %0b/%0h", cyc, bus.query1Ready, bus.query1Value, expRdy1, expVal1); end
      checkCount++; if (bus.query2Ready !== expRdy2 || (expRdy2 && bus.query2Value !== expVal2)) begin
        failCount++; $display("[TB] FAIL rand_query2 cyc %0d: got rdy=%0b val=%0h expected %0b/%0h", cyc, bus.query2Ready, bus.query2Value, expRdy2, expVal2); end
      applyStimulus();
      checkCount++; if ({bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue} !== {mWriteFlag, mRobId, mWriteAddr, mWriteValue}) begin
        failCount++; $display("[TB] FAIL rand_commit cyc %0d: got flag=%0b id=%0d addr=%0d val=%0h expected %0b/%0d/%0d/%0h",
                              cyc, bus.writeFlag, bus.robId, bus.writeAddr, bus.writeValue, mWriteFlag, mRobId, mWriteAddr, mWriteValue); end
      checkCount++; if ({bus.clearOut, bus.clearPc} !== {mClearOut, mClearPc}) begin
        failCount++; $display("[TB] FAIL rand_clear cyc %0d: got clear=%0b pc=%0h expected %0b/%0h", cyc, bus.clearOut, bus.clearPc, mClearOut, mClearPc); end
    end
    resetIn = 1'b0;
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_fill();
    test_out_of_order_commit();
    test_query_forward();
    test_zero_rd();
    test_mispredict_flush();
    test_ready_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_WIDTH, default 4, sets the entry-id width; depth is 2^ROB_WIDTH entries.
REQ-002 clockIn  in  1  single clock; all state updates on posedge.
REQ-003 resetIn  in  1  synchronous, active-high reset.
REQ-004 readyIn  in  1  global enable; when low, no state change.
REQ-005 issueValid in 1 / issueHasRd in 1 / issueRd in 5  allocation request from instruction unit: destination flag and register.
REQ-006 issueId  out  ROB_WIDTH  tail index granted to the current request (combinational); full  out  1  no free entry; empty  out  1  no valid entry.
REQ-007 cdbValid in 1 / cdbId in ROB_WIDTH / cdbValue in 32 / cdbMispredict in 1 / cdbTarget in 32  completion broadcast.
REQ-008 query1Id, query2Id  in  ROB_WIDTH; query1Ready, query2Ready  out  1; query1Value, query2Value  out  32  operand lookup by rename tag.
REQ-009 writeFlag out 1 / robId out ROB_WIDTH / writeAddr out 5 / writeValue out 32  registered commit to register file.
REQ-010 clearOut  out  1 / clearPc  out  32  registered flush pulse and redirect target.

Function
REQ-011 Circular buffer: head, tail, count; head and tail wrap modulo 2^ROB_WIDTH; full = (count == depth); empty = (count == 0).
REQ-012 Issue accepted when issueValid & !full & readyIn & no flush this cycle; entry[tail] gets valid=1, ready=0, hasRd, rd, mispredict=0; tail increments.
REQ-013 full is from current count only; a commit in the same cycle does not free space for a same-cycle issue.
REQ-014 cdbValid & readyIn & entry[cdbId].valid: set ready=1, value=cdbValue, mispredict=cdbMispredict, target=cdbTarget; CDB to an invalid entry is ignored.
REQ-015 queryNReady = entry valid & (ready | (cdbValid & cdbId == queryNId)); queryNValue forwards cdbValue on a CDB match, else stored value; combinational.
REQ-016 Commit: at most one per cycle, when entry[head] valid & ready & readyIn; head increments; entry invalidated.
REQ-017 Commit drives next cycle: writeFlag = hasRd & (rd != 0), robId = head index, writeAddr = rd, writeValue = value; writeFlag is a one-cycle pulse, 0 otherwise.
REQ-018 An entry completed by CDB in cycle N is committable no earlier than cycle N+1.
REQ-019 Commit of a mispredict entry: register write per REQ-017 still issued, and next cycle clearOut=1, clearPc=target for one cycle.
REQ-020 Same edge as a mispredict commit: all valid bits cleared, head=tail=0, count=0; a same-cycle issue or CDB write is discarded.
REQ-021 count update: +1 on issue, -1 on commit, unchanged on both; forced 0 on flush.
REQ-022 readyIn low: pointers, entries, count held; writeFlag and clearOut driven 0 next cycle.

Reset
REQ-023 resetIn high dominates all other inputs.
REQ-024 On reset: head=tail=count=0, all valid/ready/mispredict bits 0.
REQ-025 On reset, registered outputs writeFlag, robId, writeAddr, writeValue, clearOut, clearPc are all 0.
REQ-026 After reset: empty=1, full=0, issueId=0.

Structure
REQ-027 Shared package holds ROB_WIDTH default, register-index width 5, data width 32, ZERO register index 0.
REQ-028 Operand lookup with CDB forwarding SHALL be one sub-module, rob_query_port, instantiated twice.
REQ-029 Entry storage as per-field arrays; no other sub-modules.

Verification
REQ-030 Issue 16 entries (rd=1..16) -> issueId 0..15, full=1 after 16th; 17th issueValid ignored, tail stays 0.
REQ-031 CDB id 2 value 0x55 first, then ids 0,1 -> commits only after id 0 ready; writeFlag pulses for rd 1,2,3 in order, writeAddr/robId match.
REQ-032 Query id 3 while cdbValid, cdbId=3, cdbValue=0xABCD -> query1Ready=1, query1Value=0xABCD same cycle.
REQ-033 Entry with rd=0 commits -> writeFlag=0, head advances, count decrements.
REQ-034 Head entry mispredict, target 0x1000, issue same cycle -> clearOut=1, clearPc=0x1000 next cycle; empty=1, issueId=0.
REQ-035 readyIn low for 3 cycles with head ready -> no commit, writeFlag=0; commit occurs the cycle after readyIn returns high.
